// File: rtl/flanger_delay_line_if.sv
// SRAM-side bus of the flanger delay line: one address, read/write strobes,
// write data out and read data back (valid the cycle after mem_re).
interface flanger_delay_line_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_re,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_re,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/flanger_delay_line.sv
// Flanger delay line: per request, reads the sample cur_delay behind wr_ptr, returns it,
// then writes the new sample at wr_ptr. cur_delay follows a triangle LFO.
module flanger_delay_line #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MIN_DELAY = 16,
    parameter int unsigned MAX_DELAY = 512,
    parameter int unsigned LFO_DIV   = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                flanger_en,
    input  logic                sram_rw,
    input  logic [DATA_W-1:0]   write_data,
    output logic [DATA_W-1:0]   sram_data,
    output logic                data_valid,
    output logic                busy,
    output logic                overrun,
    flanger_delay_line_if.master mem
);
    localparam int unsigned DIV_W = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(LFO_DIV - 1);
    localparam logic [ADDR_W-1:0] DLY_MIN  = ADDR_W'(MIN_DELAY);
    localparam logic [ADDR_W-1:0] DLY_MAX  = ADDR_W'(MAX_DELAY);

    typedef enum logic [1:0] {StIdle, StRead, StWait, StWrite} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] cur_delay_q, cur_delay_d;
    logic [ADDR_W-1:0] delay_step;
    logic              dir_up_q, dir_up_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DATA_W-1:0] sram_data_q, sram_data_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        fill_d        = fill_q;
        cur_delay_d   = cur_delay_q;
        dir_up_d      = dir_up_q;
        div_cnt_d     = div_cnt_q;
        sram_data_d   = sram_data_q;
        sample_d      = sample_q;
        overrun_d     = overrun_q;
        delay_step    = dir_up_q ? cur_delay_q + ADDR_W'(1) : cur_delay_q - ADDR_W'(1);
        mem.mem_addr  = '0;
        mem.mem_re    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_wdata = '0;
        busy          = 1'b0;
        data_valid    = 1'b0;

        // A request that arrives mid-transaction is lost; remember that it happened.
        if (state_q != StIdle && sram_rw && flanger_en) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!flanger_en) begin
                    cur_delay_d = DLY_MIN;
                    dir_up_d    = 1'b1;
                    div_cnt_d   = '0;
                end
                if (sram_rw && flanger_en) begin
                    sample_d = write_data;
                    state_d  = StRead;
                end
            end
            StRead: begin
                busy         = 1'b1;
                mem.mem_re   = 1'b1;
                mem.mem_addr = wr_ptr_q - cur_delay_q;
                state_d      = StWait;
            end
            StWait: begin
                busy = 1'b1;
                // Locations not yet written since reset read back as silence.
                sram_data_d = (fill_q >= cur_delay_q) ? mem.mem_rdata : '0;
                state_d     = StWrite;
            end
            StWrite: begin
                busy          = 1'b1;
                data_valid    = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = wr_ptr_q;
                mem.mem_wdata = sample_q;
                wr_ptr_d      = wr_ptr_q + ADDR_W'(1);
                if (fill_q != '1) begin
                    fill_d = fill_q + ADDR_W'(1);
                end
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d   = '0;
                    cur_delay_d = delay_step;
                    if (delay_step == DLY_MAX) begin
                        dir_up_d = 1'b0;
                    end else if (delay_step == DLY_MIN) begin
                        dir_up_d = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            cur_delay_q <= DLY_MIN;
            dir_up_q    <= 1'b1;
            div_cnt_q   <= '0;
            sram_data_q <= '0;
            sample_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            cur_delay_q <= cur_delay_d;
            dir_up_q    <= dir_up_d;
            div_cnt_q   <= div_cnt_d;
            sram_data_q <= sram_data_d;
            sample_q    <= sample_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sram_data = sram_data_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_flanger_delay_line.sv
// Bench for flanger_delay_line: random samples checked against a history-queue model
// with a closed-form triangle sweep for the delay.
module tb_flanger_delay_line;
    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 32;
    localparam int          DMIN = 2;
    localparam int          DMAX = 4;
    localparam int          DIV  = 2;
    localparam int          DEPTH = 16;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          flanger_en = 1'b0;
    logic          sram_rw = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] sram_data;
    logic          data_valid;
    logic          busy;
    logic          overrun;

    flanger_delay_line_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    flanger_delay_line #(
        .ADDR_W(AW), .DATA_W(DW), .MIN_DELAY(DMIN), .MAX_DELAY(DMAX), .LFO_DIV(DIV)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .flanger_en (flanger_en),
        .sram_rw    (sram_rw),
        .write_data (write_data),
        .sram_data  (sram_data),
        .data_valid (data_valid),
        .busy       (busy),
        .overrun    (overrun),
        .mem        (mem_bus.master)
    );

    always #5 clk = ~clk;

    // SRAM with one cycle of read latency
    logic [DW-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (mem_bus.mem_we) sram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
        if (mem_bus.mem_re) mem_bus.mem_rdata <= sram[mem_bus.mem_addr];
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: every sample ever written since reset, plus a sweep index.
    logic [DW-1:0] hist[$];
    int total = 0;
    int lfo_k = 0;
    int e_delay, e_raddr, e_waddr;
    logic [DW-1:0] e_data;
    logic [DW-1:0] last_data = '0;

    // Observations of one transaction
    logic          o_r_re, o_r_busy, o_t_busy, o_t_we, o_w_we, o_w_dv, o_i_busy, o_i_dv;
    logic [AW-1:0] o_r_addr, o_w_addr;
    logic [DW-1:0] o_w_wdata, o_w_sram;

    function automatic int tri_delay(input int k);
        int span, p;
        span = DMAX - DMIN;
        p = (k / DIV) % (2 * span);
        return (p <= span) ? DMIN + p : DMAX - (p - span);
    endfunction

    task automatic model_expect();
        int fill;
        e_delay = tri_delay(lfo_k);
        e_raddr = (((total - e_delay) % DEPTH) + DEPTH) % DEPTH;
        e_waddr = total % DEPTH;
        fill = (total > DEPTH - 1) ? DEPTH - 1 : total;
        if (fill >= e_delay) e_data = hist[total - e_delay];
        else e_data = '0;
    endtask

    task automatic model_commit(input logic [DW-1:0] s);
        hist.push_back(s);
        total++;
        lfo_k++;
        last_data = e_data;
    endtask

    task automatic model_reset();
        hist.delete();
        total = 0;
        lfo_k = 0;
        last_data = '0;
    endtask

    // Starts at #1 after a rising edge with the DUT idle; ends the same way.
    task automatic run_txn(input logic [DW-1:0] s, input bit inj_read, input bit inj_wait,
                           input bit drop_en);
        write_data = s;
        sram_rw = 1'b1;
        @(posedge clk); #1;
        o_r_re = mem_bus.mem_re; o_r_addr = mem_bus.mem_addr; o_r_busy = busy;
        sram_rw = inj_read;
        @(posedge clk); #1;
        o_t_busy = busy; o_t_we = mem_bus.mem_we;
        sram_rw = inj_wait;
        if (drop_en) flanger_en = 1'b0;
        @(posedge clk); #1;
        o_w_we = mem_bus.mem_we; o_w_addr = mem_bus.mem_addr; o_w_wdata = mem_bus.mem_wdata;
        o_w_dv = data_valid; o_w_sram = sram_data;
        sram_rw = 1'b0;
        @(posedge clk); #1;
        o_i_busy = busy; o_i_dv = data_valid;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        flanger_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (sram_data !== '0 || data_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%h dv=%b ovr=%b busy=%b, want 0 0 0 0",
                     sram_data, data_valid, overrun, busy);
        end
        vectors++;
        if (mem_bus.mem_re !== 1'b0 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== '0 ||
            mem_bus.mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_mem_bus: got re=%b we=%b addr=%0d wdata=%h, want all 0",
                     mem_bus.mem_re, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata);
        end
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_first();
        model_expect();
        run_txn(32'hA, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (o_r_re !== 1'b1 || o_r_addr !== 4'd14 || o_r_addr !== AW'(e_raddr)) begin
            miscompares++;
            $display("FAIL first_read: got re=%b addr=%0d, want re=1 addr=14", o_r_re, o_r_addr);
        end
        vectors++;
        if (o_r_busy !== 1'b1 || o_t_busy !== 1'b1 || o_t_we !== 1'b0) begin
            miscompares++;
            $display("FAIL first_busy: got read=%b wait=%b wait_we=%b, want 1 1 0",
                     o_r_busy, o_t_busy, o_t_we);
        end
        vectors++;
        if (o_w_we !== 1'b1 || o_w_addr !== 4'd0 || o_w_wdata !== 32'hA || o_w_dv !== 1'b1) begin
            miscompares++;
            $display("FAIL first_write: got we=%b addr=%0d wdata=%h dv=%b, want 1 0 a 1",
                     o_w_we, o_w_addr, o_w_wdata, o_w_dv);
        end
        vectors++;
        if (o_w_sram !== '0 || o_w_sram !== e_data) begin
            miscompares++;
            $display("FAIL first_data: got %h, want 0", o_w_sram);
        end
        vectors++;
        if (o_i_busy !== 1'b0 || o_i_dv !== 1'b0) begin
            miscompares++;
            $display("FAIL first_idle: got busy=%b dv=%b, want 0 0", o_i_busy, o_i_dv);
        end
        model_commit(32'hA);
    endtask

    task automatic test_stream();
        logic [DW-1:0] s;
        for (int i = 0; i < 19; i++) begin
            s = $urandom;
            model_expect();
            run_txn(s, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (o_r_re !== 1'b1 || o_r_addr !== AW'(e_raddr)) begin
                miscompares++;
                $display("FAIL stream_read[%0d]: got re=%b addr=%0d, want 1 %0d",
                         i, o_r_re, o_r_addr, e_raddr);
            end
            vectors++;
            if (o_w_sram !== e_data) begin
                miscompares++;
                $display("FAIL stream_data[%0d]: got %h, want %h", i, o_w_sram, e_data);
            end
            vectors++;
            if (o_w_we !== 1'b1 || o_w_addr !== AW'(e_waddr) || o_w_wdata !== s ||
                o_w_dv !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_write[%0d]: got we=%b addr=%0d wdata=%h dv=%b, want 1 %0d %h 1",
                         i, o_w_we, o_w_addr, o_w_wdata, o_w_dv, e_waddr, s);
            end
            model_commit(s);
        end
    endtask

    task automatic test_enable();
        logic [DW-1:0] s;
        s = $urandom;
        model_expect();
        run_txn(s, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (o_w_we !== 1'b1 || o_w_addr !== AW'(e_waddr) || o_w_wdata !== s ||
            o_w_sram !== e_data) begin
            miscompares++;
            $display("FAIL en_drop_write: got we=%b addr=%0d wdata=%h data=%h, want 1 %0d %h %h",
                     o_w_we, o_w_addr, o_w_wdata, o_w_sram, e_waddr, s, e_data);
        end
        model_commit(s);
        lfo_k = 0;
        sram_rw = 1'b1;
        write_data = $urandom;
        @(posedge clk); #1;
        sram_rw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (busy !== 1'b0 || mem_bus.mem_re !== 1'b0 || overrun !== 1'b0 ||
                sram_data !== last_data) begin
                miscompares++;
                $display("FAIL en_ignore[%0d]: got busy=%b re=%b ovr=%b data=%h, want 0 0 0 %h",
                         i, busy, mem_bus.mem_re, overrun, sram_data, last_data);
            end
            @(posedge clk); #1;
        end
        flanger_en = 1'b1;
        s = $urandom;
        model_expect();
        run_txn(s, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (o_r_addr !== AW'((total - DMIN) % DEPTH) || o_w_sram !== e_data) begin
            miscompares++;
            $display("FAIL en_delay_restart: got addr=%0d data=%h, want %0d %h",
                     o_r_addr, o_w_sram, (total - DMIN) % DEPTH, e_data);
        end
        model_commit(s);
    endtask

    task automatic test_overrun();
        logic [DW-1:0] s;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: got %b, want 0", overrun);
        end
        s = $urandom;
        model_expect();
        run_txn(s, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (o_r_addr !== AW'(e_raddr) || o_w_addr !== AW'(e_waddr) || o_w_wdata !== s ||
            o_w_sram !== e_data) begin
            miscompares++;
            $display("FAIL overrun_inflight: got raddr=%0d waddr=%0d wdata=%h data=%h, want %0d %0d %h %h",
                     o_r_addr, o_w_addr, o_w_wdata, o_w_sram, e_raddr, e_waddr, s, e_data);
        end
        vectors++;
        if (overrun !== 1'b1 || o_i_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_set: got ovr=%b busy=%b, want 1 0", overrun, o_i_busy);
        end
        model_commit(s);
        s = $urandom;
        model_expect();
        run_txn(s, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (overrun !== 1'b1 || o_w_sram !== e_data || o_r_addr !== AW'(e_raddr)) begin
            miscompares++;
            $display("FAIL overrun_sticky: got ovr=%b data=%h addr=%0d, want 1 %h %0d",
                     overrun, o_w_sram, o_r_addr, e_data, e_raddr);
        end
        model_commit(s);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] s;
        int waddr;
        logic we_seen;
        s = $urandom;
        waddr = total % DEPTH;
        write_data = s;
        sram_rw = 1'b1;
        @(posedge clk); #1;
        sram_rw = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b0;
        #2;
        vectors++;
        if (busy !== 1'b1 || sram_data !== last_data || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_no_edge: got busy=%b data=%h ovr=%b, want 1 %h 1",
                     busy, sram_data, overrun, last_data);
        end
        @(posedge clk); #1;
        we_seen = mem_bus.mem_we;
        vectors++;
        if (busy !== 1'b0 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== '0 ||
            sram_data !== '0 || overrun !== 1'b0 || data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got busy=%b we=%b addr=%0d data=%h ovr=%b dv=%b, want all 0",
                     busy, mem_bus.mem_we, mem_bus.mem_addr, sram_data, overrun, data_valid);
        end
        @(posedge clk); #1;
        we_seen = we_seen | mem_bus.mem_we;
        n_rst = 1'b1;
        vectors++;
        if (we_seen !== 1'b0 || sram[waddr] === s) begin
            miscompares++;
            $display("FAIL rst_no_write: got we_seen=%b mem[%0d]=%h, want 0 and not %h",
                     we_seen, waddr, sram[waddr], s);
        end
        model_reset();
        s = $urandom;
        model_expect();
        run_txn(s, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (o_r_addr !== 4'd14 || o_w_addr !== 4'd0 || o_w_sram !== '0 || o_w_wdata !== s) begin
            miscompares++;
            $display("FAIL rst_restart: got raddr=%0d waddr=%0d data=%h wdata=%h, want 14 0 0 %h",
                     o_r_addr, o_w_addr, o_w_sram, o_w_wdata, s);
        end
        model_commit(s);
    endtask

    initial begin
        test_reset();
        test_first();
        test_stream();
        test_enable();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
